// File: rtl/menu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | menu_pkg : shared types and defaults for the home-screen menu        |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package menu_pkg;

  typedef enum logic {
    ST_HOME = 1'b0,
    ST_PAGE = 1'b1
  } state_t;

  localparam int IDX_W          = 2;
  localparam int DEF_N_ITEMS    = 4;
  localparam int DEF_DB_CYCLES  = 500000;
  localparam int DEF_DB_W       = 20;

  // Bit positions of the press vector built in menu_ctrl
  localparam int BTN_UP   = 0;
  localparam int BTN_DOWN = 1;
  localparam int BTN_OK   = 2;
  localparam int BTN_BACK = 3;

endpackage
`default_nettype wire

// File: rtl/menu_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce : 2-flop sync, hold-time debounce, one-shot press pulse |
// | Rev 1.0      : initial release                                       |
// +----------------------------------------------------------------------+
module btn_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int DB_W      = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [DB_W-1:0] c_CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic            r_sync1;
  logic            r_sync2;
  logic [DB_W-1:0] r_cnt;
  logic            r_level;
  logic            r_level_d;
  logic            r_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      // New level must persist DB_CYCLES consecutive cycles to be accepted
      if (r_sync2 != r_level) begin
        if (r_cnt == c_CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/menu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | menu_ctrl : button-driven menu cursor/page FSM, committed at vsync   |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
module menu_ctrl
  import menu_pkg::*;
#(
  parameter int N_ITEMS   = DEF_N_ITEMS,
  parameter int DB_CYCLES = DEF_DB_CYCLES,
  parameter int DB_W      = DEF_DB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_ok,
  input  logic             btn_back,
  input  logic             vs,
  output logic [IDX_W-1:0] sel_idx,
  output logic             page_active,
  output logic [IDX_W-1:0] page_id,
  output logic             frame_tick
);

  localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_ITEMS - 1);

  logic [3:0]       w_raw;
  logic [3:0]       w_press;

  state_t           r_state;
  state_t           w_state_nx;
  logic [IDX_W-1:0] r_pend_sel;
  logic [IDX_W-1:0] w_pend_sel_nx;
  logic [IDX_W-1:0] r_pend_page;
  logic [IDX_W-1:0] w_pend_page_nx;
  logic             r_vs_d;
  logic             w_vs_rise;

  logic [IDX_W-1:0] r_sel_idx;
  logic             r_page_active;
  logic [IDX_W-1:0] r_page_id;
  logic             r_frame_tick;

  assign w_raw = {btn_back, btn_ok, btn_down, btn_up};

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    btn_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .i_btn   (w_raw[gi]),
      .o_press (w_press[gi])
    );
  end

  assign w_vs_rise = vs & ~r_vs_d;

  always_comb begin
    w_state_nx     = r_state;
    w_pend_sel_nx  = r_pend_sel;
    w_pend_page_nx = r_pend_page;
    case (r_state)
      ST_HOME: begin
        // back outranks everything but has no effect on the home menu
        if (w_press[BTN_BACK]) begin
          w_state_nx = ST_HOME;
        end else if (w_press[BTN_OK]) begin
          w_state_nx     = ST_PAGE;
          w_pend_page_nx = r_pend_sel;
        end else if (w_press[BTN_UP] && !w_press[BTN_DOWN]) begin
          w_pend_sel_nx = (r_pend_sel == '0) ? c_LAST_IDX : r_pend_sel - 1'b1;
        end else if (w_press[BTN_DOWN] && !w_press[BTN_UP]) begin
          w_pend_sel_nx = (r_pend_sel == c_LAST_IDX) ? '0 : r_pend_sel + 1'b1;
        end
      end
      ST_PAGE: begin
        if (w_press[BTN_BACK]) begin
          w_state_nx = ST_HOME;
        end
      end
      default: w_state_nx = ST_HOME;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_HOME;
      r_pend_sel    <= '0;
      r_pend_page   <= '0;
      r_vs_d        <= 1'b0;
      r_sel_idx     <= '0;
      r_page_active <= 1'b0;
      r_page_id     <= '0;
      r_frame_tick  <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_pend_sel   <= w_pend_sel_nx;
      r_pend_page  <= w_pend_page_nx;
      r_vs_d       <= vs;
      r_frame_tick <= w_vs_rise;
      // Commit takes the post-action pending values so a same-cycle press is included
      if (w_vs_rise) begin
        r_sel_idx     <= w_pend_sel_nx;
        r_page_active <= (w_state_nx == ST_PAGE);
        r_page_id     <= w_pend_page_nx;
      end
    end
  end

  assign sel_idx     = r_sel_idx;
  assign page_active = r_page_active;
  assign page_id     = r_page_id;
  assign frame_tick  = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_menu_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_menu_ctrl : directed self-checking bench for menu_ctrl            |
// | Rev 1.0      : initial release                                       |
// +----------------------------------------------------------------------+
module tb_menu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_ok = 1'b0;
  logic       btn_back = 1'b0;
  logic       vs = 1'b0;
  logic [1:0] sel_idx;
  logic       page_active;
  logic [1:0] page_id;
  logic       frame_tick;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int last_tick_cyc = 0;
  int tick_gap = 0;
  logic seen_tick = 1'b0;
  logic m_vsd = 1'b0;
  logic m_chk = 1'b0;
  logic m_tick_exp = 1'b0;

  menu_ctrl #(
    .N_ITEMS   (4),
    .DB_CYCLES (4),
    .DB_W      (3)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_ok      (btn_ok),
    .btn_back    (btn_back),
    .vs          (vs),
    .sel_idx     (sel_idx),
    .page_active (page_active),
    .page_id     (page_id),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: the inputs set now are sampled by the coming posedge
  task automatic step();
    m_tick_exp = rst ? 1'b0 : (vs & ~m_vsd);
    m_vsd      = rst ? 1'b0 : vs;
    @(negedge clk);
    if (m_chk) chk("frame_tick", frame_tick, m_tick_exp);
    m_chk = 1'b1;
    if (frame_tick === 1'b1) begin
      tick_gap      = cyc - last_tick_cyc;
      last_tick_cyc = cyc;
      seen_tick     = 1'b1;
    end
    cyc++;
    vs = ((cyc % 200) >= 190);
  endtask

  task automatic press(input logic [3:0] m);
    {btn_back, btn_ok, btn_down, btn_up} = m;
    repeat (10) step();
    {btn_back, btn_ok, btn_down, btn_up} = 4'b0000;
    repeat (10) step();
  endtask

  task automatic wait_commit();
    int n;
    seen_tick = 1'b0;
    n = 0;
    while (!seen_tick && n < 400) begin
      step();
      n++;
    end
    if (!seen_tick) chk("commit_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [1:0] s, input logic pa, input logic [1:0] pid);
    chk({tag, "_sel"}, 32'(sel_idx), 32'(s));
    chk({tag, "_pa"},  32'(page_active), 32'(pa));
    chk({tag, "_pid"}, 32'(page_id), 32'(pid));
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    chk_out("reset", 2'd0, 1'b0, 2'd0);
    chk("reset_tick", 32'(frame_tick), 32'd0);

    // Idle frames
    wait_commit();
    chk_out("idle1", 2'd0, 1'b0, 2'd0);
    wait_commit();
    chk_out("idle2", 2'd0, 1'b0, 2'd0);
    chk("frame_period", 32'(tick_gap), 32'd200);

    // Bouncing up, then a clean hold: a single up action, wrapping 0 -> 3
    btn_up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i % 2 == 1) btn_up = ~btn_up;
    end
    btn_up = 1'b1;
    repeat (10) step();
    btn_up = 1'b0;
    repeat (10) step();
    chk("up_not_yet_visible", 32'(sel_idx), 32'd0);
    wait_commit();
    chk_out("up_wrap", 2'd3, 1'b0, 2'd0);

    // Three downs in one frame: 3 -> 0 -> 1 -> 2, only 2 becomes visible
    press(4'b0010);
    chk("down1_hidden", 32'(sel_idx), 32'd3);
    press(4'b0010);
    chk("down2_hidden", 32'(sel_idx), 32'd3);
    press(4'b0010);
    chk("down3_hidden", 32'(sel_idx), 32'd3);
    wait_commit();
    chk_out("down3", 2'd2, 1'b0, 2'd0);

    // Enter page 2, up/down ignored there, back returns to entry 2
    press(4'b0100);
    wait_commit();
    chk_out("ok_page", 2'd2, 1'b1, 2'd2);
    press(4'b0001);
    press(4'b0010);
    wait_commit();
    chk_out("page_ignore", 2'd2, 1'b1, 2'd2);
    press(4'b1000);
    wait_commit();
    chk_out("back_home", 2'd2, 1'b0, 2'd2);

    // Move to 1, then simultaneous up+down cancels
    press(4'b0001);
    wait_commit();
    chk_out("up_to1", 2'd1, 1'b0, 2'd2);
    press(4'b0011);
    wait_commit();
    chk_out("updown_cancel", 2'd1, 1'b0, 2'd2);

    // ok beats up in the same cycle
    press(4'b0101);
    wait_commit();
    chk_out("ok_over_up", 2'd1, 1'b1, 2'd1);

    // Reset mid-frame with an ok press still being debounced
    repeat (20) step();
    btn_ok = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    btn_ok = 1'b0;
    step();
    rst = 1'b0;
    chk_out("midreset", 2'd0, 1'b0, 2'd0);
    chk("midreset_tick", 32'(frame_tick), 32'd0);
    wait_commit();
    chk_out("after_reset", 2'd0, 1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
